serial_parallel_rx: RTL and testbench

SERIAL_PARALLEL_RX -- requirements
Module: serial_parallel_rx

---
 rtl/serial_parallel_rx_if.sv | 25 ++
 rtl/serial_parallel_rx.sv | 136 +++++++++++++
 tb/tb_serial_parallel_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parallel_rx_if.sv
// Serial receiver bundle: one-bit stream in, decoded byte and status out.
// The receiver takes the slave side; the stream source takes the master side.
interface serial_parallel_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver with COM-based byte alignment (SEARCH/ALIGN/ACTIVE).
// Define SP_RX_RESYNC_EN to allow realignment on an off-boundary COM while ACTIVE.
module serial_parallel_rx (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    serial_parallel_rx_if.slave  bus
);
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] sr;
    logic [7:0] nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_nx;
    logic [1:0] com_cnt;
    logic [1:0] com_nx;
    logic [7:0] dout;
    logic [7:0] dout_nx;
    logic       valid;
    logic       valid_nx;
    logic       strobe;
    logic       strobe_nx;
    logic       is_com;
    logic       is_idl;
    logic       boundary;
    logic       resync;

    assign nxt      = {sr[6:0], bus.data_in};
    assign is_com   = (nxt == COM);
    assign is_idl   = (nxt == IDL);
    assign boundary = (bit_cnt == 3'd7);

`ifdef SP_RX_RESYNC_EN
    assign resync = is_com && !boundary;
`else
    assign resync = 1'b0;
`endif

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt + 3'd1;
        com_nx   = com_cnt;
        unique case (state)
            SEARCH: begin
                bit_nx = 3'd0;
                if (is_com) begin
                    state_nx = ALIGN;
                    com_nx   = 2'd1;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_nx = com_cnt + 2'd1;
                        // com_cnt already holds three, so this is the fourth
                        if (com_cnt == 2'd3) begin
                            state_nx = ACTIVE;
                        end
                    end else begin
                        state_nx = SEARCH;
                        com_nx   = 2'd0;
                    end
                end
            end
            ACTIVE: begin
                if (resync) begin
                    state_nx = ALIGN;
                    bit_nx   = 3'd0;
                    com_nx   = 2'd1;
                end
            end
            default: begin
                state_nx = SEARCH;
                bit_nx   = 3'd0;
                com_nx   = 2'd0;
            end
        endcase
    end

    // Byte capture only happens on a boundary already inside ACTIVE;
    // the entry edge from ALIGN keeps the cleared outputs.
    always_comb begin
        dout_nx   = dout;
        valid_nx  = valid;
        strobe_nx = 1'b0;
        if (state_nx != ACTIVE) begin
            dout_nx  = 8'h00;
            valid_nx = 1'b0;
        end else if (state == ACTIVE && boundary) begin
            dout_nx   = nxt;
            valid_nx  = !(is_com || is_idl);
            strobe_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
            com_cnt <= 2'd0;
            dout    <= 8'h00;
            valid   <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            sr      <= nxt;
            bit_cnt <= bit_nx;
            com_cnt <= com_nx;
            dout    <= dout_nx;
            valid   <= valid_nx;
            strobe  <= strobe_nx;
        end
    end

    always_comb begin
        bus.active      = (state == ACTIVE);
        bus.data_out    = dout;
        bus.valid_out   = valid;
        bus.byte_strobe = strobe;
    end
endmodule

// File: tb/tb_serial_parallel_rx.sv
// Bench for serial_parallel_rx: per-cycle reference model plus directed scenarios.
// Expectations follow SP_RX_RESYNC_EN the same way as the design.
module tb_serial_parallel_rx;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;

    serial_parallel_rx_if bus ();

    serial_parallel_rx dut (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk_32f = ~clk_32f;

    int vec = 0;
    int bad = 0;
    int scount = 0;
    logic seen_drop;

    // Reference model: mode 0 hunting, 1 counting COMs, 2 in service.
    // Byte boundaries sit at bit counts anchor + 8k.
    int         m_mode;
    int         m_n;
    int         m_anchor;
    int         m_coms;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_strobe;

    typedef struct {
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t tab [6];

    task automatic model_reset();
        m_mode   = 0;
        m_n      = 0;
        m_anchor = 0;
        m_coms   = 0;
        m_win    = 8'h00;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_strobe = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic on_b;
        m_n++;
        m_win    = {m_win[6:0], b};
        m_strobe = 1'b0;
        on_b     = ((m_n - m_anchor) % 8) == 0;
        if (m_mode == 0) begin
            if (m_win == COM) begin
                m_mode   = 1;
                m_anchor = m_n;
                m_coms   = 1;
            end
        end else if (m_mode == 1) begin
            if (on_b) begin
                if (m_win == COM) begin
                    m_coms++;
                    if (m_coms == 4) m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_coms = 0;
                end
            end
        end else begin
            if (on_b) begin
                m_data   = m_win;
                m_valid  = (m_win != COM) && (m_win != IDL);
                m_strobe = 1'b1;
            end
`ifdef SP_RX_RESYNC_EN
            else if (m_win == COM) begin
                m_mode   = 1;
                m_anchor = m_n;
                m_coms   = 1;
            end
`endif
        end
        if (m_mode != 2) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [10:0] got,
                         input logic [10:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {bus.data_out, bus.valid_out, bus.byte_strobe, bus.active};
    endfunction

    task automatic step(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check("cycle", outs(), {m_data, m_valid, m_strobe, m_mode == 2});
        if (bus.byte_strobe) scount++;
        if (!bus.active) seen_drop = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) send_byte(COM);
    endtask

    task automatic do_reset();
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check("async_reset", outs(), 11'h000);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        tab[0] = '{8'hFF, 8'hFF, 1'b1};
        tab[1] = '{8'hEE, 8'hEE, 1'b1};
        tab[2] = '{8'h7C, 8'h7C, 1'b0};
        tab[3] = '{8'hDD, 8'hDD, 1'b1};
        tab[4] = '{8'hBC, 8'hBC, 1'b0};
        tab[5] = '{8'h00, 8'h00, 1'b1};

        bus.data_in = 1'b0;
        model_reset();
        #2;
        check("reset_state", outs(), 11'h000);
        #4;
        reset_L = 1'b1;

        // Four COMs: active rises exactly on the 32nd bit
        send_coms(3);
        for (int i = 7; i >= 1; i--) step(COM[i]);
        check("pre_active", {10'h0, bus.active}, 11'h000);
        step(COM[0]);
        check("active_rise", outs(), 11'h001);

        scount = 0;
        for (int k = 0; k < 6; k++) begin
            send_byte(tab[k].b);
            check("table_byte", outs(),
                  {tab[k].exp_data, tab[k].exp_valid, 1'b1, 1'b1});
        end
        check("strobe_count", 11'(scount), 11'd6);

        // Broken COM run falls back to SEARCH
        do_reset();
        send_coms(3);
        send_byte(8'hAA);
        check("aa_no_active", {10'h0, bus.active}, 11'h000);
        send_coms(4);
        check("realign_after_aa", {10'h0, bus.active}, 11'h001);

        // Three junk bits shift the alignment
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        send_coms(3);
        for (int i = 7; i >= 1; i--) step(COM[i]);
        check("off3_pre", {10'h0, bus.active}, 11'h000);
        step(COM[0]);
        check("off3_active", {10'h0, bus.active}, 11'h001);
        send_byte(8'h55);
        check("off3_byte", outs(), {8'h55, 1'b1, 1'b1, 1'b1});

        // Reset mid-byte in ACTIVE
        for (int i = 7; i >= 4; i--) step(1'b1);
        do_reset();
        send_coms(3);
        check("rst_need_four", {10'h0, bus.active}, 11'h000);
        send_coms(1);
        check("rst_reacquire", {10'h0, bus.active}, 11'h001);

        // One-bit slip while in service
        seen_drop = 1'b0;
        step(1'b0);
        send_coms(4);
`ifdef SP_RX_RESYNC_EN
        check("slip_drop", {10'h0, seen_drop}, 11'h001);
        check("slip_reacq", {10'h0, bus.active}, 11'h001);
        send_byte(8'hA5);
        check("slip_byte", outs(), {8'hA5, 1'b1, 1'b1, 1'b1});
`else
        check("slip_no_drop", {10'h0, seen_drop}, 11'h000);
        check("slip_stay", {10'h0, bus.active}, 11'h001);
`endif

        // Random traffic: bytes, COM bursts, slips, rare resets
        for (int k = 0; k < 160; k++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 3) begin
                send_coms(4);
            end else if (r == 3) begin
                step(1'($urandom_range(0, 1)));
            end else if (r == 4) begin
                if ($urandom_range(0, 4) == 0) do_reset();
                else send_byte(IDL);
            end else if (r == 5) begin
                send_byte(COM);
            end else begin
                send_byte(8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
